// File: rtl/spi_master_cfg.sv
// Parametrised SPI master: configurable frame width, SCLK divider and chip-select count,
// all four CPOL/CPHA modes and MSB/LSB-first order, latched per frame.
module spi_master_cfg #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 2,
  parameter int NUM_CS  = 2,
  localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
  localparam int BW     = $clog2(DATA_W)
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              i_tx_vd,
  output logic              o_tx_ready,
  input  logic [DATA_W-1:0] i_tx_parallel,
  input  logic              i_cpol,
  input  logic              i_cpha,
  input  logic              i_lsb_first,
  input  logic [CS_W-1:0]   i_cs_sel,
  output logic [DATA_W-1:0] o_rx_parallel,
  output logic              o_rx_vd,
  output logic              o_busy,
  output logic [BW-1:0]     o_bit_count,
  output logic              o_spi_clk,
  output logic              o_mosi,
  input  logic              i_miso,
  output logic [NUM_CS-1:0] o_cs_n
);

  localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HW = $clog2(2 * DATA_W);
  localparam logic [TW-1:0] TIMER_LAST = TW'(CLK_DIV - 1);
  localparam logic [HW-1:0] HALF_LAST  = HW'(2 * DATA_W - 1);
  localparam logic [BW-1:0] LAST_BIT   = BW'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  state_t            state;
  logic [TW-1:0]     timer;
  logic [HW-1:0]     half_cnt;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] rx_shift;
  logic              cpol_q;
  logic              cpha_q;
  logic              lsb_q;

  logic [NUM_CS-1:0] cs_dec_n;
  logic              first_bit;
  logic [BW-1:0]     bit_idx;
  logic              sample_edge;
  logic              timer_done;

  // An out-of-range chip-select index decodes to no select at all.
  always_comb begin
    cs_dec_n = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (i_cs_sel == CS_W'(i)) cs_dec_n[i] = 1'b0;
    end
  end

  // The bit counter doubles as the frame position for both the next MOSI bit and the MISO slot.
  always_comb begin
    first_bit   = i_lsb_first ? i_tx_parallel[0] : i_tx_parallel[DATA_W-1];
    bit_idx     = lsb_q ? o_bit_count : LAST_BIT - o_bit_count;
    sample_edge = (~half_cnt[0]) != cpha_q;
    timer_done  = (timer == TIMER_LAST);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state         <= IDLE;
      timer         <= '0;
      half_cnt      <= '0;
      data_q        <= '0;
      rx_shift      <= '0;
      cpol_q        <= 1'b0;
      cpha_q        <= 1'b0;
      lsb_q         <= 1'b0;
      o_tx_ready    <= 1'b1;
      o_rx_parallel <= '0;
      o_rx_vd       <= 1'b0;
      o_busy        <= 1'b0;
      o_bit_count   <= '0;
      o_spi_clk     <= 1'b0;
      o_mosi        <= 1'b0;
      o_cs_n        <= '1;
    end else begin
      o_rx_vd <= 1'b0;
      case (state)
        IDLE: begin
          o_spi_clk <= i_cpol;
          if (i_tx_vd && o_tx_ready) begin
            data_q      <= i_tx_parallel;
            cpol_q      <= i_cpol;
            cpha_q      <= i_cpha;
            lsb_q       <= i_lsb_first;
            o_cs_n      <= cs_dec_n;
            o_tx_ready  <= 1'b0;
            o_busy      <= 1'b1;
            o_bit_count <= '0;
            timer       <= '0;
            half_cnt    <= '0;
            state       <= SETUP;
            if (!i_cpha) o_mosi <= first_bit;
          end
        end

        SETUP: begin
          if (timer_done) begin
            timer <= '0;
            state <= XFER;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        // Each SCLK edge lands at the end of a half-period; the final edge returns SCLK to CPOL.
        XFER: begin
          if (timer_done) begin
            timer     <= '0;
            o_spi_clk <= ~o_spi_clk;
            half_cnt  <= half_cnt + 1'b1;
            if (sample_edge) begin
              rx_shift[bit_idx] <= i_miso;
              o_bit_count       <= o_bit_count + 1'b1;
            end else if (half_cnt != HALF_LAST) begin
              o_mosi <= data_q[bit_idx];
            end
            if (half_cnt == HALF_LAST) state <= HOLD;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        HOLD: begin
          o_spi_clk <= cpol_q;
          if (timer_done) begin
            timer         <= '0;
            o_cs_n        <= '1;
            o_rx_vd       <= 1'b1;
            o_rx_parallel <= rx_shift;
            o_tx_ready    <= 1'b1;
            o_busy        <= 1'b0;
            o_bit_count   <= '0;
            state         <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
